// File: rtl/mem_port_arbiter.sv
// Arbitrates a single multi-cycle memory port between instruction fetch (I) and
// the memory stage (D). D wins ties unless it has starved a pending I request.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          m_en,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_done,
    output logic          err
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state_q;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] timer_q;
    logic          m_en_q, m_wr_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q, i_rdata_q, d_rdata_q;
    logic          i_done_q, d_done_q, err_q;

    logic i_elig, d_elig, grant_d, grant_i;

    // A request whose done pulse is showing this cycle is already served.
    always_comb begin
        i_elig   = i_req & ~i_done_q;
        d_elig   = d_req & ~d_done_q;
        grant_d  = (state_q == IDLE) & d_elig & (~i_elig | (streak_q < STREAK_LIM));
        grant_i  = (state_q == IDLE) & i_elig & ~grant_d;
        streak_d = streak_q;
        if (grant_d) begin
            if (!i_elig)
                streak_d = '0;
            else if (streak_q != STREAK_LIM)
                streak_d = streak_q + 1'b1;
        end else if (grant_i) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            timer_q   <= '0;
            m_en_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            m_en_q   <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            streak_q <= streak_d;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (m_done)
                        err_q <= 1'b1;
                    if (grant_d) begin
                        state_q   <= BUSY_D;
                        m_en_q    <= 1'b1;
                        m_wr_q    <= d_wr;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                    end else if (grant_i) begin
                        state_q   <= BUSY_I;
                        m_en_q    <= 1'b1;
                        m_wr_q    <= 1'b0;
                        m_addr_q  <= i_addr;
                        m_wdata_q <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_done) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        // A withdrawn request still gets its data, just no done pulse.
                        if (state_q == BUSY_I) begin
                            i_rdata_q <= m_rdata;
                            i_done_q  <= i_req;
                        end else begin
                            d_rdata_q <= m_rdata;
                            d_done_q  <= d_req;
                        end
                    end else if (timer_q == TMO_LAST) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_stall = i_req & ~i_done_q;
    assign d_stall = d_req & ~d_done_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign m_en    = m_en_q;
    assign m_wr    = m_wr_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table with hand-driven memory
// responses, then model-backed sequences for streak, flush and timeout.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        i_req, i_done, i_stall;
    logic [15:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_done, d_stall;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        m_en, m_wr, m_done;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic        err;

    logic        tb_done;
    logic [15:0] tb_rdata;
    logic        mdl_on, hold, mdl_done;
    logic [15:0] mdl_rdata, lat;
    logic [1:0]  cnt;

    int checks = 0;
    int failures = 0;

    assign m_done  = tb_done | mdl_done;
    assign m_rdata = mdl_on ? mdl_rdata : tb_rdata;

    mem_port_arbiter #(.AW(16), .DW(16), .STREAK_MAX(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory answers 2 cycles after m_en with addr ^ FFFF unless held off.
    always @(negedge clk) begin
        if (rst || !mdl_on) begin
            cnt      <= '0;
            mdl_done <= 1'b0;
        end else begin
            mdl_done <= 1'b0;
            if (cnt != 0) begin
                cnt <= cnt - 1'b1;
                if (cnt == 2'd1) begin
                    mdl_done  <= 1'b1;
                    mdl_rdata <= lat ^ 16'hFFFF;
                end
            end
            if (!hold && m_en) begin
                cnt <= 2'd2;
                lat <= m_addr;
            end
        end
    end

    typedef struct packed {
        logic        rst, i_req;
        logic [15:0] i_addr;
        logic        d_req, d_wr;
        logic [15:0] d_addr, d_wdata;
        logic        m_done;
        logic [15:0] m_rdata;
    } vin_t;

    typedef struct packed {
        logic        m_en, m_wr;
        logic [15:0] m_addr, m_wdata;
        logic        i_done;
        logic [15:0] i_rdata;
        logic        i_stall, d_done;
        logic [15:0] d_rdata;
        logic        d_stall, err;
    } vout_t;

    typedef struct {
        vin_t  in;
        vout_t exp;
    } vec_t;

    function automatic vin_t vi(logic r, logic ir, logic [15:0] ia, logic dr, logic dw,
                                logic [15:0] da, logic [15:0] dwd, logic md, logic [15:0] mr);
        vin_t v;
        v = '{r, ir, ia, dr, dw, da, dwd, md, mr};
        return v;
    endfunction

    function automatic vout_t vo(logic me, logic mw, logic [15:0] ma, logic [15:0] mwd,
                                 logic id, logic [15:0] ird, logic is, logic dd,
                                 logic [15:0] drd, logic ds, logic e);
        vout_t v;
        v = '{me, mw, ma, mwd, id, ird, is, dd, drd, ds, e};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; tb_done = 1'b0; tb_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[19];

    initial begin
        vout_t act;
        logic [5:0] pat;
        int ng, ni, n;
        logic raise, saw, found;

        rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        tb_done = 0; tb_rdata = '0; mdl_on = 0; hold = 0;

        // fetch grant and completion, stray m_done, D-first tie, reset in BUSY_D
        tbl[0]  = '{vi(1,0,16'h0,0,0,16'h0,16'h0,0,16'h0),        vo(0,0,16'h0,16'h0,0,16'h0,0,0,16'h0,0,0)};
        tbl[1]  = '{vi(0,1,16'h0010,0,0,16'h0,16'h0,0,16'h0),     vo(1,0,16'h0010,16'h0,0,16'h0,1,0,16'h0,0,0)};
        tbl[2]  = '{vi(0,1,16'h0010,0,0,16'h0,16'h0,0,16'h0),     vo(0,0,16'h0010,16'h0,0,16'h0,1,0,16'h0,0,0)};
        tbl[3]  = '{vi(0,1,16'h0010,0,0,16'h0,16'h0,0,16'h0),     vo(0,0,16'h0010,16'h0,0,16'h0,1,0,16'h0,0,0)};
        tbl[4]  = '{vi(0,1,16'h0010,0,0,16'h0,16'h0,1,16'hFFEF),  vo(0,0,16'h0010,16'h0,1,16'hFFEF,0,0,16'h0,0,0)};
        tbl[5]  = '{vi(0,0,16'h0,0,0,16'h0,16'h0,0,16'h0),        vo(0,0,16'h0010,16'h0,0,16'hFFEF,0,0,16'h0,0,0)};
        tbl[6]  = '{vi(0,0,16'h0,0,0,16'h0,16'h0,1,16'h1111),     vo(0,0,16'h0010,16'h0,0,16'hFFEF,0,0,16'h0,0,1)};
        tbl[7]  = '{vi(0,0,16'h0,0,0,16'h0,16'h0,0,16'h0),        vo(0,0,16'h0010,16'h0,0,16'hFFEF,0,0,16'h0,0,1)};
        tbl[8]  = '{vi(1,0,16'h0,0,0,16'h0,16'h0,0,16'h0),        vo(0,0,16'h0,16'h0,0,16'h0,0,0,16'h0,0,0)};
        tbl[9]  = '{vi(0,1,16'h0030,1,1,16'h0200,16'hBEEF,0,16'h0),    vo(1,1,16'h0200,16'hBEEF,0,16'h0,1,0,16'h0,1,0)};
        tbl[10] = '{vi(0,1,16'h0030,1,1,16'h0200,16'hBEEF,0,16'h0),    vo(0,1,16'h0200,16'hBEEF,0,16'h0,1,0,16'h0,1,0)};
        tbl[11] = '{vi(0,1,16'h0030,1,1,16'h0200,16'hBEEF,0,16'h0),    vo(0,1,16'h0200,16'hBEEF,0,16'h0,1,0,16'h0,1,0)};
        tbl[12] = '{vi(0,1,16'h0030,1,1,16'h0200,16'hBEEF,1,16'h1234), vo(0,1,16'h0200,16'hBEEF,0,16'h0,1,1,16'h1234,0,0)};
        tbl[13] = '{vi(0,1,16'h0030,1,1,16'h0200,16'hBEEF,0,16'h0),    vo(1,0,16'h0030,16'h0,0,16'h0,1,0,16'h1234,1,0)};
        tbl[14] = '{vi(1,0,16'h0,0,0,16'h0,16'h0,0,16'h0),        vo(0,0,16'h0,16'h0,0,16'h0,0,0,16'h0,0,0)};
        tbl[15] = '{vi(0,0,16'h0,1,0,16'h0400,16'h0,0,16'h0),     vo(1,0,16'h0400,16'h0,0,16'h0,0,0,16'h0,1,0)};
        tbl[16] = '{vi(1,0,16'h0,1,0,16'h0400,16'h0,0,16'h0),     vo(0,0,16'h0,16'h0,0,16'h0,0,0,16'h0,1,0)};
        tbl[17] = '{vi(0,0,16'h0,0,0,16'h0,16'h0,1,16'h5555),     vo(0,0,16'h0,16'h0,0,16'h0,0,0,16'h0,0,1)};
        tbl[18] = '{vi(1,0,16'h0,0,0,16'h0,16'h0,0,16'h0),        vo(0,0,16'h0,16'h0,0,16'h0,0,0,16'h0,0,0)};

        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            rst = tbl[k].in.rst; i_req = tbl[k].in.i_req; i_addr = tbl[k].in.i_addr;
            d_req = tbl[k].in.d_req; d_wr = tbl[k].in.d_wr; d_addr = tbl[k].in.d_addr;
            d_wdata = tbl[k].in.d_wdata; tb_done = tbl[k].in.m_done; tb_rdata = tbl[k].in.m_rdata;
            @(posedge clk);
            #1;
            act = {m_en, m_wr, m_addr, m_wdata, i_done, i_rdata, i_stall,
                   d_done, d_rdata, d_stall, err};
            chk($sformatf("vec%0d", k), 128'(act), 128'(tbl[k].exp));
        end

        // Streak: I shows up at every D grant edge, then gives way again.
        do_reset;
        mdl_on = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000; i_req = 1'b1; i_addr = 16'h1000;
        pat = '0; ng = 0; ni = 0; raise = 1'b0;
        for (int c = 0; c < 200 && ng < 6; c++) begin
            @(negedge clk);
            if (m_en) begin
                ng++;
                pat = {pat[4:0], (m_addr[15:12] == 4'h2)};
                if (m_addr[15:12] == 4'h2) i_req = 1'b0;
                else ni++;
            end
            if (i_done) i_req = 1'b0;
            if (raise) begin
                if (ni == 0) i_req = 1'b1;
                raise = 1'b0;
            end
            if (d_done) begin
                d_addr = d_addr + 16'h1;
                raise  = 1'b1;
            end
        end
        chk("streak_grants", 128'(ng), 128'(6));
        chk("streak_order", 128'(pat), 128'(6'b111101));
        chk("streak_i_rdata", 128'(i_rdata), 128'(16'hEFFF));

        // Fetch withdrawn one cycle after m_en.
        do_reset;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0050;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (m_en) found = 1'b1;
        end
        chk("flush_m_en", 128'(found), 128'(1));
        @(negedge clk);
        i_req = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (i_done) saw = 1'b1;
        end
        chk("flush_no_done", 128'(saw), 128'(0));
        chk("flush_rdata", 128'(i_rdata), 128'(16'hFFAF));
        chk("flush_err", 128'(err), 128'(0));
        i_req = 1'b1; i_addr = 16'h0060;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (i_done) found = 1'b1;
        end
        chk("refetch_done", 128'(found), 128'(1));
        chk("refetch_rdata", 128'(i_rdata), 128'(16'hFF9F));

        // Timeout: memory never answers.
        do_reset;
        hold = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0700;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (m_en) found = 1'b1;
        end
        n = 0; saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (d_done) saw = 1'b1;
            if (err) break;
        end
        chk("timeout_cycles", 128'(n), 128'(16));
        @(negedge clk);
        chk("timeout_regrant", 128'(m_en), 128'(1));
        d_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("timeout_no_done", 128'(saw | d_done), 128'(0));
        chk("err_sticky", 128'(err), 128'(1));
        do_reset;
        hold = 1'b0;
        chk("err_cleared", 128'(err), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, multi-cycle backing memory between instruction fetch (I side) and the memory stage (D side) of the 5-stage pipeline.
- Grants one transaction at a time and gives the D side priority, because its instruction is older.
- A streak limit guarantees the I side progress.
- Generates the per-requester stalls that drive pipeline freeze, and a sticky err that is ORed into the processor err.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- STREAK_MAX, 4, max consecutive D grants while an I request is pending.
- TIMEOUT, 16, max cycles to wait for m_done after m_en.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request, level, held until i_done.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetch read data, valid while i_done=1.
- i_done  out  1  one-cycle completion pulse.
- i_stall  out  1  i_req & ~i_done.
- d_req  in  1  data request, level, held until d_done.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  read data, valid while d_done=1.
- d_done  out  1  one-cycle completion pulse.
- d_stall  out  1  d_req & ~d_done.
- m_en  out  1  one-cycle issue strobe to memory.
- m_wr  out  1  write qualifier, valid with m_en.
- m_addr  out  AW  memory address, registered.
- m_wdata  out  DW  memory write data, registered.
- m_rdata  in  DW  memory read data, valid with m_done.
- m_done  in  1  memory completion, one-cycle pulse.
- err  out  1  sticky protocol/timeout error.

Behaviour:
- Reset (rst=1 at an edge) gives the following on the next cycle:
  - state=IDLE, streak=0, timer=0.
  - m_en=0, m_wr=0, m_addr=0, m_wdata=0.
  - i_done=0, d_done=0, i_rdata=0, d_rdata=0, err=0.
  - Reset mid-transaction abandons it with no done pulse. Memory is reset by the same rst.
- States: IDLE, BUSY_I, BUSY_D.
- Eligibility: a request is eligible in IDLE only if its done output is 0 in that cycle. This prevents re-granting a held req on its completion cycle.
- Grant in IDLE, evaluated at the edge:
  - D eligible and (I not eligible or streak<STREAK_MAX) -> BUSY_D.
  - Otherwise, if I eligible -> BUSY_I.
  - Otherwise stay IDLE.
- On grant:
  - m_en=1 for exactly the next cycle.
  - m_addr, m_wr, m_wdata are captured from the granted side. I side forces m_wr=0 and m_wdata=0.
  - Address and data hold until the next grant.
- Streak counter:
  - A D grant while I is eligible -> streak+1, saturating at STREAK_MAX.
  - Any I grant, or a D grant with I not eligible -> streak=0.
- In BUSY_x, m_done=1 at edge:
  - x_rdata<=m_rdata. It holds until that side's next completion.
  - x_done=1 for one cycle.
  - state->IDLE, timer=0.
  - For writes, d_rdata is still loaded from m_rdata and is don't-care.
- Earliest turnaround:
  - req seen at edge N -> m_en in cycle N+1.
  - m_done in cycle M -> done in cycle M+1.
  - Next grant evaluated at edge M+1, giving m_en in cycle M+2.
- Requester drops req while BUSY (e.g. branch flush of fetch):
  - The transaction still completes and rdata still updates.
  - x_done is suppressed if x_req=0 at the m_done edge.
  - No err.
- Timeout:
  - The timer counts cycles in BUSY since m_en.
  - Reaching TIMEOUT without m_done -> err=1, state->IDLE, no done pulse.
- m_done while IDLE -> err=1 and the pulse is ignored.
- err is sticky until rst.
- Stalls are combinational from req and registered done. No other combinational input-to-output paths.
- Address and data inputs must be stable while req is high. Only grant-edge values are used.

Test Plan:
Memory model returns m_done 2 cycles after m_en, rdata=addr^16'hFFFF.
1. Reset, then i_req=1 with i_addr=16'h0010 -> m_en pulses 1 cycle later with m_addr=16'h0010, m_wr=0; i_done pulses with i_rdata=16'hFFEF; i_stall=1 until that cycle; err=0.
2. i_req and d_req rise the same cycle (d_wr=1, d_addr=16'h0200, d_wdata=16'hBEEF) -> D granted first (m_wr=1, m_wdata=16'hBEEF); I granted the cycle after d_done; no duplicate D grant.
3. d_req held continuously with new addresses each completion, i_req held -> exactly 4 D grants, then 1 I grant, then streak=0 and D resumes.
4. i_req dropped one cycle after its m_en -> no i_done; i_rdata still updates; next request proceeds normally; err=0.
5. Memory model withholds m_done -> err=1 exactly 16 cycles after m_en; state IDLE; err stays 1 until rst; after rst, err=0.
6. rst asserted while in BUSY_D -> next cycle all outputs at reset values, no d_done; stray m_done while IDLE -> err=1.
